// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-throughs onto one fixed-latency main memory.
// Round-robin between the two requesters. Each grant is serviced to completion before IDLE re-arbitrates.
module mem_arbiter #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [2:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        i_fsm_busy,
  output logic        d_fsm_busy
);

  localparam int unsigned CntW = $clog2(WORDS + LAT);
  localparam logic [CntW-1:0] LatC   = CntW'(LAT);
  localparam logic [CntW-1:0] WordsC = CntW'(WORDS);
  localparam logic [CntW-1:0] LastC  = CntW'(WORDS + LAT - 1);

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            last_gnt_q, last_gnt_d;  // 1: D was granted last
  logic            grant_d;
  logic            fill_we;
  logic            fill_done;
  logic [CntW-1:0] idx_c;

  assign idx_c = cnt_q - LatC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_idx   = '0;
    fill_data  = '0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    d_done     = 1'b0;
    // On a tie, D wins unless D was the last one served.
    grant_d    = d_req && (!i_req || !last_gnt_q);

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d    = d_wr ? StDWrite : StDFill;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          last_gnt_d = 1'b1;
          cnt_d      = '0;
        end else if (i_req) begin
          state_d    = StIFill;
          addr_d     = i_addr;
          last_gnt_d = 1'b0;
          cnt_d      = '0;
        end
      end
      StIFill, StDFill: begin
        if (cnt_q < WordsC) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[15:4], 4'b0000} + 16'({cnt_q, 1'b0});
        end
        // Write strobes come from the counter alone, so stale returns never land in a cache.
        if (cnt_q >= LatC) begin
          fill_we   = 1'b1;
          fill_idx  = 3'(idx_c);
          fill_data = mem_rdata;
        end
        if (cnt_q == LastC) begin
          fill_done = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
          addr_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDWrite: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        state_d   = StIdle;
        addr_d    = '0;
        wdata_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    i_fill_we  = fill_we && (state_q == StIFill);
    d_fill_we  = fill_we && (state_q == StDFill);
    i_done     = fill_done && (state_q == StIFill);
    d_done     = d_done || (fill_done && (state_q == StDFill));
    i_fsm_busy = i_req || (state_q == StIFill);
    d_fsm_busy = d_req || (state_q == StDFill) || (state_q == StDWrite);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus for mem_arbiter, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int LAT      = 4;
  localparam int WORDS    = 8;
  localparam int FILL_LEN = WORDS + LAT;
  localparam int K_NONE = 0, K_IF = 1, K_DF = 2, K_DW = 3;

  logic        clk = 1'b0;
  logic        rst, i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done, i_fsm_busy, d_fsm_busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_idx;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .i_fsm_busy(i_fsm_busy), .d_fsm_busy(d_fsm_busy)
  );

  // Memory: a read issued in cycle t returns 0xA000 + word-in-block during cycle t+LAT.
  logic        pipe_v [LAT];
  logic [15:0] pipe_a [LAT];
  always @(posedge clk) begin
    pipe_v[0] <= mem_en && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_a[k] <= pipe_a[k-1];
    end
  end
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 | {13'd0, a[3:1]};
  endfunction
  assign mem_rdata = (pipe_v[LAT-1] === 1'b1) ? mem_word(pipe_a[LAT-1]) : 16'hDEAD;

  int          checks = 0, failures = 0, cyc = 0;
  int          kind = K_NONE, c = 0;
  logic [15:0] m_addr, m_wdata;
  bit          m_last_d = 1'b0;
  bit          i_again = 1'b0, d_again = 1'b0;
  int          i_done_cyc = -1, d_done_cyc = -1;
  byte         done_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_cycle();
    logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_ibusy, e_dbusy;
    logic [15:0] e_addr, e_wdata, e_fdata;
    logic [2:0]  e_idx;
    bit          pick_d;
    @(negedge clk);
    {e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone} = '0;
    e_addr = '0; e_wdata = '0; e_fdata = '0; e_idx = '0;
    e_ibusy = i_req || (kind == K_IF);
    e_dbusy = d_req || (kind == K_DF) || (kind == K_DW);
    if (kind == K_IF || kind == K_DF) begin
      if (c < WORDS) begin
        e_en   = 1'b1;
        e_addr = (m_addr & 16'hFFF0) + 16'(2 * c);
      end
      if (c >= LAT) begin
        if (kind == K_IF) e_iwe = 1'b1; else e_dwe = 1'b1;
        e_idx   = 3'(c - LAT);
        e_fdata = 16'hA000 + 16'(c - LAT);
      end
      if (c == FILL_LEN - 1) begin
        if (kind == K_IF) e_idone = 1'b1; else e_ddone = 1'b1;
      end
    end else if (kind == K_DW) begin
      e_en = 1'b1; e_wr = 1'b1; e_addr = m_addr; e_wdata = m_wdata; e_ddone = 1'b1;
    end
    chk("mem_en",     32'(mem_en),     32'(e_en));
    chk("mem_wr",     32'(mem_wr),     32'(e_wr));
    chk("mem_addr",   32'(mem_addr),   32'(e_addr));
    chk("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
    chk("i_fill_we",  32'(i_fill_we),  32'(e_iwe));
    chk("d_fill_we",  32'(d_fill_we),  32'(e_dwe));
    chk("fill_idx",   32'(fill_idx),   32'(e_idx));
    chk("fill_data",  32'(fill_data),  32'(e_fdata));
    chk("i_done",     32'(i_done),     32'(e_idone));
    chk("d_done",     32'(d_done),     32'(e_ddone));
    chk("i_fsm_busy", 32'(i_fsm_busy), 32'(e_ibusy));
    chk("d_fsm_busy", 32'(d_fsm_busy), 32'(e_dbusy));
    if (i_done === 1'b1) begin done_q.push_back("I"); i_done_cyc = cyc; end
    if (d_done === 1'b1) begin done_q.push_back("D"); d_done_cyc = cyc; end
    // Advance the transaction model across the coming edge.
    if (rst) begin
      kind = K_NONE; m_last_d = 1'b0;
    end else if (kind != K_NONE) begin
      c++;
      if (c == ((kind == K_DW) ? 1 : FILL_LEN)) kind = K_NONE;
    end else if (i_req || d_req) begin
      pick_d   = d_req && (!i_req || !m_last_d);
      m_last_d = pick_d;
      c        = 0;
      if (pick_d) begin
        kind = d_wr ? K_DW : K_DF; m_addr = d_addr; m_wdata = d_wdata;
      end else begin
        kind = K_IF; m_addr = i_addr;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (e_idone) begin
      i_req = 1'b0;
      if (i_again) begin i_req = 1'b1; i_addr = 16'($urandom); end
    end
    if (e_ddone) begin
      d_req = 1'b0;
      if (d_again) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom); end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int  t;
    byte exp_o [4];
    exp_o = '{"D", "I", "D", "I"};
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1; cyc++;
    run_cycle();  // outputs in the cycle after a reset edge
    rst = 1'b0;
    run_cycles(2);

    // Single I fill from 0x1234.
    t = cyc; i_req = 1'b1; i_addr = 16'h1234;
    run_cycles(FILL_LEN + 3);
    chk("i_fill_done_time", 32'(i_done_cyc), 32'(t + 12));

    // Simultaneous requests right after reset: D first.
    do_reset();
    t = cyc; i_req = 1'b1; i_addr = 16'h4C0A; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7FFE;
    run_cycles(28);
    chk("tie_d_done_time", 32'(d_done_cyc), 32'(t + 12));
    chk("tie_i_done_time", 32'(i_done_cyc), 32'(t + 25));

    // Continuous re-requests alternate D, I, D, I.
    do_reset();
    done_q.delete();
    i_again = 1'b1; d_again = 1'b1;
    i_req = 1'b1; i_addr = 16'($urandom); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
    run_cycles(52);
    i_again = 1'b0; d_again = 1'b0; i_req = 1'b0; d_req = 1'b0;
    run_cycles(2);
    chk("rr_count", 32'(done_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < done_q.size(); k++) chk("rr_order", 32'(done_q[k]), 32'(exp_o[k]));

    // Single-word write-through.
    t = cyc; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
    run_cycles(3);
    chk("write_done_time", 32'(d_done_cyc), 32'(t + 1));

    // Reset at fill cycle c=6, stale returns must not be written, then a clean fill.
    t = cyc; i_req = 1'b1; i_addr = 16'h9A5C;
    run_cycles(7);
    rst = 1'b1; i_req = 1'b0;
    run_cycle();
    rst = 1'b0;
    run_cycles(1);
    chk("abort_no_done", 32'(i_done_cyc > t), 32'd0);
    t = cyc; i_req = 1'b1; i_addr = 16'h0F31;
    run_cycles(FILL_LEN + 2);
    chk("refill_done_time", 32'(i_done_cyc), 32'(t + 12));

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      end else begin
        rst = 1'b0;
        if (!i_req && $urandom_range(2) == 0) begin i_req = 1'b1; i_addr = 16'($urandom); end
        if (!d_req && $urandom_range(2) == 0) begin
          d_req = 1'b1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end
      run_cycle();
    end
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    run_cycles(FILL_LEN + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
